elastic_pipeline: RTL

Parametrised valid/ready register pipeline: NUM_STAGES register slices carrying DATA_WIDTH-bit words, with per-stage valid bits, bubble collapsing, back-pressure, synchronous flush and an occupancy output. It replaces plain CE-driven shift registers wherever a timing-closure pipeline must sit on a streaming handshake interface. An optional skid mode registers the ready path per stage, so back-pressure never forms a combinational chain across stages.

---
 rtl/elastic_pipeline.sv | 133 +++++++++++++
 1 files changed

// File: rtl/elastic_pipeline.sv
// elastic_pipeline: valid/ready register pipeline with bubble collapsing, optional per-stage
// skid buffers (fully registered ready path), synchronous flush and a live occupancy count.
module elastic_pipeline #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 2,
  parameter int SKID       = 0,
  localparam int CAP       = NUM_STAGES * (1 + SKID),
  localparam int OCC_W     = $clog2(CAP + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  S_VALID,
  output logic                  S_READY,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic [OCC_W-1:0]      OCCUPANCY
);

  logic                  clear;
  logic [NUM_STAGES-1:0] main_valid;
  logic [NUM_STAGES-1:0] skid_valid;
  logic [NUM_STAGES:0]   ready;
  logic [DATA_WIDTH-1:0] main_data [NUM_STAGES];
  logic [NUM_STAGES-1:0] up_valid;
  logic [DATA_WIDTH-1:0] up_data [NUM_STAGES];
  logic [OCC_W-1:0]      occ_next;

  assign clear = RST || FLUSH;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_up
      if (gi == 0) begin : g_head
        assign up_valid[gi] = S_VALID;
        assign up_data[gi]  = S_DATA;
      end else begin : g_link
        assign up_valid[gi] = main_valid[gi-1];
        assign up_data[gi]  = main_data[gi-1];
      end
    end

    if (SKID == 0) begin : g_plain
      assign skid_valid = '0;

      // An empty stage always accepts, so the ready chain lets bubbles collapse.
      always_comb begin
        ready[NUM_STAGES] = M_READY;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
          ready[i] = !main_valid[i] || ready[i+1];
        end
      end

      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic                  valid_reg;
        logic [DATA_WIDTH-1:0] data_reg;

        always_ff @(posedge CLK) begin
          if (RST) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else if (FLUSH) begin
            valid_reg <= 1'b0;
          end else if (ready[gi]) begin
            valid_reg <= up_valid[gi];
            if (up_valid[gi]) begin
              data_reg <= up_data[gi];
            end
          end
        end

        assign main_valid[gi] = valid_reg;
        assign main_data[gi]  = data_reg;
      end
    end else begin : g_skid
      // Each stage's ready is just its empty skid slot, so nothing chains combinationally.
      assign ready = {M_READY, ~skid_valid};

      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        logic                  main_valid_reg;
        logic                  skid_valid_reg;
        logic [DATA_WIDTH-1:0] main_data_reg;
        logic [DATA_WIDTH-1:0] skid_data_reg;
        logic                  accept;

        assign accept = up_valid[gi] && !skid_valid_reg;

        always_ff @(posedge CLK) begin
          if (RST) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_data_reg  <= '0;
          end else if (FLUSH) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
          end else if (!main_valid_reg || ready[gi+1]) begin
            main_valid_reg <= skid_valid_reg || accept;
            skid_valid_reg <= 1'b0;
            if (skid_valid_reg) begin
              main_data_reg <= skid_data_reg;
            end else if (accept) begin
              main_data_reg <= up_data[gi];
            end
          end else if (accept) begin
            skid_data_reg  <= up_data[gi];
            skid_valid_reg <= 1'b1;
          end
        end

        assign main_valid[gi] = main_valid_reg;
        assign skid_valid[gi] = skid_valid_reg;
        assign main_data[gi]  = main_data_reg;
      end
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occ_next = occ_next + OCC_W'(main_valid[i]) + OCC_W'(skid_valid[i]);
    end
  end

  // Gating both handshake outputs during clear guarantees no transfer in that cycle.
  assign S_READY   = ready[0] && !clear;
  assign M_VALID   = main_valid[NUM_STAGES-1] && !clear;
  assign M_DATA    = main_data[NUM_STAGES-1];
  assign OCCUPANCY = occ_next;

endmodule
